// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM CPU-port arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DS_W   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitData,
    StDone
  } arb_state_e;

  // Increment modulo n, used to advance the round-robin pointer past a grant.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin encoder: first pending index at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         pending,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] grant
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [31:0] pos;

  // Scan from the farthest offset down to offset 0 so the nearest pending index wins.
  always_comb begin
    valid = |pending;
    grant = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(rr_ptr) + (NREQ - 1 - k)) % NREQ;
      if (pending[pos[IDX_W-1:0]]) begin
        grant = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_cpu_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's toggle-handshake CPU port among
// NREQ requesters, one transaction outstanding, read data held per requester.
module sdram_cpu_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_DELAY = 5
) (
  input  logic                     clk,
  input  logic                     init_n,
  input  logic [NREQ-1:0]          rq_req,
  output logic [NREQ-1:0]          rq_ack,
  input  logic [NREQ-1:0]          rq_we,
  input  logic [NREQ*ADDR_W-1:0]   rq_addr,
  input  logic [NREQ*DATA_W-1:0]   rq_din,
  input  logic [NREQ*DS_W-1:0]     rq_ds,
  output logic [NREQ*DATA_W-1:0]   rq_dout,
  output logic                     cpu_req,
  input  logic                     cpu_req_ack,
  output logic [ADDR_W-1:0]        cpu_addr,
  output logic [DATA_W-1:0]        cpu_din,
  output logic [DS_W-1:0]          cpu_ds,
  output logic                     cpu_we,
  output logic                     cpu_port,
  input  logic [DATA_W-1:0]        cpu_port0
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(DATA_DELAY + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cpu_req_q, cpu_req_d;
  logic              ack_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   rq_ack_q, rq_ack_d;
  logic [DATA_W-1:0] rq_dout_q [NREQ];
  logic [DATA_W-1:0] rq_dout_d [NREQ];
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
  logic [DS_W-1:0]   cpu_ds_q, cpu_ds_d;
  logic              cpu_we_q, cpu_we_d;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] din_arr  [NREQ];
  logic [DS_W-1:0]   ds_arr   [NREQ];

  logic [NREQ-1:0]   pending;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr_arr[i]                  = rq_addr[i*ADDR_W +: ADDR_W];
    assign din_arr[i]                   = rq_din[i*DATA_W +: DATA_W];
    assign ds_arr[i]                    = rq_ds[i*DS_W +: DS_W];
    assign rq_dout[i*DATA_W +: DATA_W]  = rq_dout_q[i];
  end

  assign pending = rq_req ^ rq_ack_q;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .pending(pending),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .grant  (pick_grant)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cpu_req_d  = cpu_req_q;
    cnt_d      = cnt_q;
    rq_ack_d   = rq_ack_q;
    rq_dout_d  = rq_dout_q;
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    cpu_ds_d   = cpu_ds_q;
    cpu_we_d   = cpu_we_q;

    unique case (state_q)
      StIdle: begin
        // cpu_* only load here, so they stay stable for the whole transaction.
        if (pick_valid) begin
          grant_d    = pick_grant;
          cpu_addr_d = addr_arr[pick_grant];
          cpu_din_d  = din_arr[pick_grant];
          cpu_ds_d   = ds_arr[pick_grant];
          cpu_we_d   = rq_we[pick_grant];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cpu_req_d = ~cpu_req_q;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        if (ack_sync_q == cpu_req_q) begin
          if (cpu_we_q) begin
            state_d = StDone;
          end else begin
            cnt_d   = CNT_W'(DATA_DELAY - 1);
            state_d = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (cnt_q == '0) begin
          rq_dout_d[grant_q] = cpu_port0;
          state_d            = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        rq_ack_d[grant_q] = rq_req[grant_q];
        rr_ptr_d          = IDX_W'(wrap_inc(32'(grant_q), NREQ));
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cpu_req_q  <= 1'b0;
      ack_sync_q <= 1'b0;
      cnt_q      <= '0;
      rq_ack_q   <= '0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_ds_q   <= '0;
      cpu_we_q   <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        rq_dout_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cpu_req_q  <= cpu_req_d;
      ack_sync_q <= cpu_req_ack;
      cnt_q      <= cnt_d;
      rq_ack_q   <= rq_ack_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      cpu_ds_q   <= cpu_ds_d;
      cpu_we_q   <= cpu_we_d;
      for (int i = 0; i < NREQ; i++) begin
        rq_dout_q[i] <= rq_dout_d[i];
      end
    end
  end

  assign rq_ack   = rq_ack_q;
  assign cpu_req  = cpu_req_q;
  assign cpu_addr = cpu_addr_q;
  assign cpu_din  = cpu_din_q;
  assign cpu_ds   = cpu_ds_q;
  assign cpu_we   = cpu_we_q;
  assign cpu_port = 1'b0;

endmodule

// File: tb/tb_sdram_cpu_arbiter.sv
// Bench for sdram_cpu_arbiter: controller stub, transaction scoreboard, vector table
// and hand-written round-robin, fairness, hold and reset sequences.
module tb_sdram_cpu_arbiter;

  localparam int NREQ       = 4;
  localparam int DATA_DELAY = 5;
  localparam int LAT_WR     = 10;
  localparam int LAT_RD     = 15;

  logic                 clk = 1'b0;
  logic                 init_n;
  logic [NREQ-1:0]      rq_req;
  logic [NREQ-1:0]      rq_ack;
  logic [NREQ-1:0]      rq_we;
  logic [NREQ*23-1:0]   rq_addr;
  logic [NREQ*16-1:0]   rq_din;
  logic [NREQ*2-1:0]    rq_ds;
  logic [NREQ*16-1:0]   rq_dout;
  logic                 cpu_req;
  logic                 cpu_req_ack;
  logic [22:0]          cpu_addr;
  logic [15:0]          cpu_din;
  logic [1:0]           cpu_ds;
  logic                 cpu_we;
  logic                 cpu_port;
  logic [15:0]          cpu_port0;

  always #5 clk = ~clk;

  sdram_cpu_arbiter #(
    .NREQ      (NREQ),
    .DATA_DELAY(DATA_DELAY)
  ) dut (
    .clk        (clk),
    .init_n     (init_n),
    .rq_req     (rq_req),
    .rq_ack     (rq_ack),
    .rq_we      (rq_we),
    .rq_addr    (rq_addr),
    .rq_din     (rq_din),
    .rq_ds      (rq_ds),
    .rq_dout    (rq_dout),
    .cpu_req    (cpu_req),
    .cpu_req_ack(cpu_req_ack),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_ds     (cpu_ds),
    .cpu_we     (cpu_we),
    .cpu_port   (cpu_port),
    .cpu_port0  (cpu_port0)
  );

  function automatic logic [15:0] resp(input logic [22:0] a);
    return (a == 23'h000100) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  // Controller stub: ack 4 cycles after the request is seen, data DATA_DELAY after ack.
  logic        prev_req;
  int          dly, dcnt;
  logic [15:0] pend_data;
  logic [42:0] obs_mem [256];
  int          obs_wr = 0;

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cpu_req_ack <= 1'b0;
      prev_req    <= 1'b0;
      dly         <= 0;
      dcnt        <= 0;
      pend_data   <= 16'h0;
      cpu_port0   <= 16'hDEAD;
    end else begin
      if (cpu_req != prev_req) begin
        prev_req              <= cpu_req;
        dly                   <= 4;
        cpu_port0             <= 16'hDEAD;
        pend_data             <= resp(cpu_addr);
        obs_mem[obs_wr % 256] <= {cpu_port, cpu_we, cpu_addr, cpu_din, cpu_ds};
        obs_wr                <= obs_wr + 1;
      end else if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          cpu_req_ack <= prev_req;
          dcnt        <= DATA_DELAY;
        end
      end
      if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) cpu_port0 <= pend_data;
      end
    end
  end

  // A requester may only toggle while it has nothing outstanding.
  logic [NREQ-1:0] req_prev = '0;
  always @(posedge clk) begin
    if (init_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rq_req[i] != req_prev[i] && req_prev[i] != rq_ack[i])
          $error("illegal double toggle on requester %0d", i);
      end
    end
    req_prev <= rq_req;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          obs_rd = 0;
  logic [41:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_drain();
    while (obs_rd != obs_wr) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_txn", 64'(obs_mem[obs_rd % 256]), 64'h0);
      end else begin
        check("sb_txn", 64'(obs_mem[obs_rd % 256]), {22'h0, 1'b0, exp_q.pop_front()});
      end
      obs_rd++;
    end
  endtask

  task automatic set_rq(input int idx, input bit we, input logic [22:0] addr,
                        input logic [15:0] din, input logic [1:0] ds);
    rq_we[idx]            = we;
    rq_addr[idx*23 +: 23] = addr;
    rq_din[idx*16 +: 16]  = din;
    rq_ds[idx*2 +: 2]     = ds;
    rq_req[idx]           = ~rq_req[idx];
    exp_q.push_back({we, addr, din, ds});
  endtask

  task automatic do_txn(input int idx, input bit we, input logic [22:0] addr,
                        input logic [15:0] din, input logic [1:0] ds);
    logic [63:0] exp_dout;
    int          lat;
    bit          done;
    @(negedge clk);
    exp_dout = rq_dout;
    if (!we) exp_dout[idx*16 +: 16] = resp(addr);
    set_rq(idx, we, addr, din, ds);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      done = (rq_ack[idx] == rq_req[idx]);
    end
    check($sformatf("latency_rq%0d", idx), 64'(lat), 64'(we ? LAT_WR : LAT_RD));
    check($sformatf("dout_after_rq%0d", idx), rq_dout, exp_dout);
    sb_drain();
  endtask

  task automatic wait_all_done(input string name, input int bound);
    int n = 0;
    while (rq_ack != rq_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(rq_ack), 64'(rq_req));
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] snap;
    logic [63:0] exp_dout;
    int          n0, bad, n;

    vecs[0] = '{0, 1'b0, 23'h000100, 16'h0000, 2'b11};
    vecs[1] = '{2, 1'b1, 23'h7F0000, 16'h1234, 2'b10};
    vecs[2] = '{1, 1'b0, 23'h012345, 16'h0000, 2'b11};
    vecs[3] = '{3, 1'b1, 23'h000001, 16'hFFFF, 2'b01};
    vecs[4] = '{2, 1'b0, 23'h7FFFFF, 16'h0000, 2'b11};
    vecs[5] = '{3, 1'b0, 23'h055AA0, 16'h0000, 2'b11};

    init_n  = 1'b0;
    rq_req  = '0;
    rq_we   = '0;
    rq_addr = '0;
    rq_din  = '0;
    rq_ds   = '0;
    repeat (3) @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);
    check("reset_rq_ack", 64'(rq_ack), 64'h0);
    check("reset_rq_dout", rq_dout, 64'h0);
    check("reset_cpu_regs", 64'({cpu_req, cpu_addr, cpu_din, cpu_ds, cpu_we, cpu_port}), 64'h0);

    // Two simultaneous bursts, both served 0,1,2,3 starting from rr_ptr=0.
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      exp_dout = rq_dout;
      for (int i = 0; i < NREQ; i++) begin
        set_rq(i, 1'b0, 23'h100000 + 23'(b * 16 + i), 16'h0, 2'b11);
        exp_dout[i*16 +: 16] = resp(23'h100000 + 23'(b * 16 + i));
      end
      wait_all_done($sformatf("burst%0d_all_acked", b), 300);
      check($sformatf("burst%0d_dout", b), rq_dout, exp_dout);
      sb_drain();
    end

    for (int v = 0; v < 6; v++) begin
      do_txn(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].din, vecs[v].ds);
    end

    // Fairness: rq0 re-requests after each ack while rq3 waits; rq3 must get the next grant.
    @(negedge clk);
    set_rq(0, 1'b0, 23'h000200, 16'h0, 2'b11);
    set_rq(3, 1'b0, 23'h000300, 16'h0, 2'b11);
    n0 = 0;
    n  = 0;
    while (rq_ack[3] != rq_req[3] && n < 200) begin
      @(negedge clk);
      n++;
      if (rq_ack[3] != rq_req[3] && rq_ack[0] == rq_req[0]) begin
        n0++;
        set_rq(0, 1'b0, 23'h000200 + 23'(n0), 16'h0, 2'b11);
      end
    end
    check("fair_rq3_served", 64'(rq_ack[3]), 64'(rq_req[3]));
    check("fair_rq0_grants_before_rq3", 64'(n0), 64'h1);
    wait_all_done("fair_rq0_tail_done", 100);
    check("fair_rq0_dout", 64'(rq_dout[15:0]), 64'(resp(23'h000201)));
    sb_drain();

    // Hold: rq1's inputs move while rq0 is in flight.
    @(negedge clk);
    snap = rq_dout;
    set_rq(0, 1'b0, 23'h0ABCDE, 16'h0, 2'b11);
    bad = 0;
    n   = 0;
    while (rq_ack[0] != rq_req[0] && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        rq_addr[1*23 +: 23] = 23'h7FFFFF;
        rq_din[1*16 +: 16]  = 16'hA5A5;
      end
      if (cpu_addr !== 23'h0ABCDE) bad++;
    end
    check("hold_cpu_addr_stable", 64'(bad), 64'h0);
    check("hold_rq0_done", 64'(rq_ack[0]), 64'(rq_req[0]));
    check("hold_rq1_dout", 64'(rq_dout[31:16]), 64'(snap[31:16]));
    sb_drain();

    // Reset in the middle of the data wait of a read.
    @(negedge clk);
    set_rq(1, 1'b0, 23'h003333, 16'h0, 2'b11);
    repeat (10) @(negedge clk);
    sb_drain();
    #2;
    init_n = 1'b0;
    rq_req = '0;
    #1;
    check("midrst_rq_ack", 64'(rq_ack), 64'h0);
    check("midrst_rq_dout", rq_dout, 64'h0);
    check("midrst_cpu_regs", 64'({cpu_req, cpu_addr, cpu_din, cpu_ds, cpu_we}), 64'h0);
    @(negedge clk);
    init_n = 1'b1;
    do_txn(2, 1'b0, 23'h000100, 16'h0, 2'b11);

    sb_drain();
    check("sb_all_expected_seen", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
